// File: rtl/fpu_result_pack_stage.sv
// fpu_result_pack_stage
//   Registered output stage of the FP32 add/sub datapath. It resolves the final
//   IEEE-754 word from the normal-path result and the special-case selector code,
//   tags it with exception flags and buffers it in a 2-entry FIFO behind a
//   valid/ready handshake.
//
//   Optional feature macro: FPU_EXC_CNT_EN builds the saturating NaN/overflow
//   pop counters. When it is undefined the count outputs are tied to 0 and
//   i_cnt_clr is ignored.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready            input handshake
//   i_add_sub                    0 = add, 1 = subtract
//   i_sign_*/i_exp_*/i_man_*     operand fields (mantissa hidden bit at [23])
//   i_sel_man                    0x normal, 10 infinity, 11 NaN
//   i_norm_sign/exp/man          normal-path result
//   o_valid / i_ready            output handshake
//   o_result, o_flag_*           head FIFO entry
//   i_cnt_clr, o_cnt_nan/ovf     saturating exception counters
module fpu_result_pack_stage #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_add_sub,
  input  logic             i_sign_a,
  input  logic             i_sign_b,
  input  logic [7:0]       i_exp_a,
  input  logic [7:0]       i_exp_b,
  input  logic [23:0]      i_man_a,
  input  logic [23:0]      i_man_b,
  input  logic [1:0]       i_sel_man,
  input  logic             i_norm_sign,
  input  logic [7:0]       i_norm_exp,
  input  logic [22:0]      i_norm_man,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic             o_flag_nan,
  output logic             o_flag_inf,
  output logic             o_flag_ovf,
  output logic             o_flag_inv,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt_nan,
  output logic [CNT_W-1:0] o_cnt_ovf
);

  // ---------------------------------------------------------------- resolve
  logic        a_is_nan;
  logic        b_is_nan;
  logic [31:0] res_word;
  logic        res_nan;
  logic        res_inf;
  logic        res_ovf;
  logic        res_inv;

  assign a_is_nan = (i_exp_a == 8'hFF) && (i_man_a[22:0] != 23'd0);
  assign b_is_nan = (i_exp_b == 8'hFF) && (i_man_b[22:0] != 23'd0);

  always_comb begin
    res_word = {i_norm_sign, i_norm_exp, i_norm_man};
    res_nan  = 1'b0;
    res_inf  = 1'b0;
    res_ovf  = 1'b0;
    res_inv  = 1'b0;
    if (i_sel_man == 2'b11) begin
      res_word = 32'h7FC0_0000;
      res_nan  = 1'b1;
      // No NaN operand means the NaN was generated here (Inf - Inf).
      res_inv  = !(a_is_nan || b_is_nan);
    end else if (i_sel_man == 2'b10) begin
      // The infinite operand decides the sign; b's sign is flipped by subtract.
      res_word = {(i_exp_a == 8'hFF) ? i_sign_a : (i_sign_b ^ i_add_sub), 8'hFF, 23'd0};
      res_inf  = 1'b1;
    end else if (i_norm_exp == 8'hFF) begin
      // Normal path rounded up into the all-ones exponent: overflow to infinity.
      res_word = {i_norm_sign, 8'hFF, 23'd0};
      res_ovf  = 1'b1;
      res_inf  = 1'b1;
    end
  end

  // ---------------------------------------------------------------- 2-entry FIFO
  // Entry layout: {result[31:0], nan, inf, ovf, inv}
  logic [35:0] mem_reg [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        ready_reg;
  logic        push;
  logic        pop;
  logic [35:0] head;

  assign o_valid = (count_reg != 2'd0);
  assign o_ready = ready_reg;
  assign push    = i_valid && ready_reg;
  assign pop     = o_valid && i_ready;
  assign head    = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 2'd1;
    else if (pop && !push)
      count_next = count_reg - 2'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++)
        mem_reg[i] <= 36'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      ready_reg  <= 1'b1;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= {res_word, res_nan, res_inf, res_ovf, res_inv};
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
      // Registered full flag, kept in lock-step with the next count.
      ready_reg <= (count_next != 2'd2);
    end
  end

  assign o_result   = head[35:4];
  assign o_flag_nan = head[3];
  assign o_flag_inf = head[2];
  assign o_flag_ovf = head[1];
  assign o_flag_inv = head[0];

  // ---------------------------------------------------------------- counters
`ifdef FPU_EXC_CNT_EN
  logic [CNT_W-1:0] cnt_nan_reg;
  logic [CNT_W-1:0] cnt_ovf_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_nan_reg <= '0;
      cnt_ovf_reg <= '0;
    end else if (i_cnt_clr) begin
      cnt_nan_reg <= '0;
      cnt_ovf_reg <= '0;
    end else if (pop) begin
      if (head[3] && (cnt_nan_reg != {CNT_W{1'b1}}))
        cnt_nan_reg <= cnt_nan_reg + CNT_W'(1);
      if (head[1] && (cnt_ovf_reg != {CNT_W{1'b1}}))
        cnt_ovf_reg <= cnt_ovf_reg + CNT_W'(1);
    end
  end

  assign o_cnt_nan = cnt_nan_reg;
  assign o_cnt_ovf = cnt_ovf_reg;

  logic unused_inputs;
  assign unused_inputs = ^{i_man_a[23], i_man_b[23]};
`else
  assign o_cnt_nan = '0;
  assign o_cnt_ovf = '0;

  logic unused_inputs;
  assign unused_inputs = ^{i_man_a[23], i_man_b[23], i_cnt_clr};
`endif

endmodule
